// File: rtl/program_counter.sv
// program_counter
//   Architectural PC register for the ARM core fetch stage. Holds the current
//   instruction address. On each rising clock edge it either advances by
//   INCREMENT or loads the redirect target Result. It also presents the
//   sequential address PC + INCREMENT to the datapath for R15 reads and link
//   values.
//
// Parameters
//   WIDTH         address/datapath width in bits
//   RESET_VECTOR  value loaded into PC while Reset is low
//   INCREMENT     sequential step (one ARM instruction = 4 bytes)
//
// Ports
//   CLK        in   system clock; all state changes on its rising edge
//   Reset      in   synchronous active-low reset
//   PCSrc      in   1 = load Result, 0 = sequential increment
//   Result     in   redirect target (branch target or value written to R15)
//   PC         out  current instruction address (registered)
//   PC_Plus_4  out  PC + INCREMENT (combinational)
module program_counter #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INCREMENT    = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_Plus_4
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(INCREMENT);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus;

    // Modulo 2^WIDTH: the carry out of the top bit is dropped on purpose, so
    // the last word of the address space wraps to 0 with no overflow flag.
    assign pc_plus = pc_reg + STEP;

    // Result is taken verbatim; alignment checking belongs to other logic.
    always_comb begin
        pc_next = pc_plus;
        if (PCSrc) begin
            pc_next = Result;
        end
    end

    // Reset is sampled only at the edge and takes priority over a redirect.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pc_reg <= RESET_VECTOR;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign PC        = pc_reg;
    assign PC_Plus_4 = pc_plus;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter
//   Self-checking bench for program_counter. The reference model keeps the
//   architectural PC as a plain 32-bit number. It applies the next-address
//   rule (reset, then redirect, then +4) once per edge. Directed sequences
//   cover the listed scenarios. Randomized cycles with between-edge glitches
//   on Reset, PCSrc and Result follow.
module tb_program_counter;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        pc_src;
    logic [31:0] result;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;

    int vectors;
    int miscompares;
    logic [31:0] model_pc;

    program_counter #(
        .WIDTH       (32),
        .RESET_VECTOR(RV),
        .INCREMENT   (4)
    ) dut (
        .CLK      (clk),
        .Reset    (reset),
        .PCSrc    (pc_src),
        .Result   (result),
        .PC       (pc),
        .PC_Plus_4(pc_plus_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
        end
    endtask

    // Drives the edge's inputs at the falling edge. When glitch is set, the
    // inputs first take junk values (Reset low, PCSrc high, random Result)
    // and settle just before the rising edge. After the edge, the bench
    // updates the model and checks both outputs. When glitch is set, it then
    // disturbs the inputs again mid-cycle and checks that nothing moved.
    task automatic step(input logic rst, input logic src, input logic [31:0] res,
                        input bit glitch, input string tag);
        @(negedge clk);
        if (glitch) begin
            reset  = 1'b0;
            pc_src = 1'b1;
            result = $urandom;
            #2;
        end
        reset  = rst;
        pc_src = src;
        result = res;
        @(posedge clk);
        #1;
        if (!rst)     model_pc = RV;
        else if (src) model_pc = res;
        else          model_pc = model_pc + 32'd4;
        check_value({tag, ".pc"}, pc, model_pc);
        check_value({tag, ".pc4"}, pc_plus_4, model_pc + 32'd4);
        $display("edge rst=%0b src=%0b res=%08h -> pc=%08h pc4=%08h",
                 rst, src, res, pc, pc_plus_4);
        if (glitch) begin
            reset  = 1'b0;
            pc_src = 1'b1;
            result = $urandom;
            #1;
            result = $urandom;
            #1;
            check_value({tag, ".hold_pc"}, pc, model_pc);
            check_value({tag, ".hold_pc4"}, pc_plus_4, model_pc + 32'd4);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_pc    = RV;
        reset       = 1'b0;
        pc_src      = 1'b0;
        result      = 32'h2914AB4E;

        // Reset is held for two edges and Result is ignored.
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h2914AB4E, 0, "reset");
        check_value("reset_abs.pc", pc, 32'h0000_0000);
        check_value("reset_abs.pc4", pc_plus_4, 32'h0000_0004);

        // Sequential counting 4 .. 0x28.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 0, "seq");
        check_value("seq_abs.pc", pc, 32'h0000_0028);

        // One-edge redirect, then sequential.
        step(1'b1, 1'b1, 32'h2914AB4E, 0, "redir");
        check_value("redir_abs.pc4", pc_plus_4, 32'h2914AB52);
        step(1'b1, 1'b0, 32'h0, 0, "redir_seq");
        step(1'b1, 1'b0, 32'h0, 0, "redir_seq");
        check_value("redir_abs.pc", pc, 32'h2914AB56);

        // Wrap-around at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 0, "wrap");
        check_value("wrap_abs.pc4", pc_plus_4, 32'h0000_0000);
        step(1'b1, 1'b0, 32'h0, 0, "wrap_seq");
        check_value("wrap_abs.pc", pc, 32'h0000_0000);

        // PCSrc held high for several edges loads Result every edge.
        step(1'b1, 1'b1, 32'h0000_1000, 0, "level");
        step(1'b1, 1'b1, 32'h0000_2000, 0, "level");
        step(1'b1, 1'b1, 32'h0000_3000, 0, "level");

        // Reset wins over a redirect; counting resumes from 4.
        step(1'b0, 1'b1, 32'h12345678, 0, "rst_wins");
        check_value("rst_wins_abs.pc", pc, 32'h0000_0000);
        step(1'b1, 1'b0, 32'h0, 0, "resume");
        check_value("resume_abs.pc", pc, 32'h0000_0004);

        // Between-edge glitches with PCSrc low at the edge: pure +4 sequence.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, $urandom, 1, "glitch");
        check_value("glitch_abs.pc", pc, 32'h0000_001C);

        // Randomized run with glitches.
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        s;
            logic [31:0] d;
            r = ($urandom_range(0, 15) != 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(r, s, d, bit'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Architectural program counter register for the single-cycle/pipelined ARM core fetch stage.
- Holds the current instruction address and presents it to instruction memory.
- Each clock it either advances sequentially by 4 or loads a redirect target (the write-back Result on branch or PC write).
- Also outputs the sequential address PC+4 for the datapath (R15 reads, link value).

Parameters:
- WIDTH, 32, address/datapath width in bits.
- RESET_VECTOR, 32'h00000000, value loaded into PC while reset is asserted.
- INCREMENT, 4, sequential step added to PC (one ARM instruction).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising CLK edge).
- PCSrc  input  1  redirect select: 1 = load Result, 0 = sequential increment.
- Result  input  WIDTH  redirect target address (branch target or ALU/memory result written to R15).
- PC  output  WIDTH  current instruction address (registered).
- PC_Plus_4  output  WIDTH  combinational PC + INCREMENT.

Behaviour:
- One clock domain (CLK), one register (PC), no other state.
- Next-state priority on each rising CLK edge:
  1. Reset==0: PC <= RESET_VECTOR.
  2. else PCSrc==1: PC <= Result.
  3. else: PC <= PC + INCREMENT.
- Reset is synchronous only. Reset going low between edges has no effect until the next rising edge.
- Reset overrides PCSrc when both are active on the same edge.
- Reset values: PC = RESET_VECTOR and PC_Plus_4 = RESET_VECTOR + INCREMENT after the first edge with Reset low.
- No power-on value is guaranteed before the first reset edge. The bench must apply reset first.
- Latency: PCSrc/Result take effect one edge later; PC reflects the new value immediately after that edge.
- PC_Plus_4 is purely combinational from PC, with no register. It changes only when PC changes and is independent of PCSrc/Result.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - Wrap-around: PC=32'hFFFFFFFC gives PC_Plus_4=32'h00000000, and the next sequential PC is 0.
  - No overflow flag.
- Result is loaded verbatim. No alignment masking (e.g. 32'h2914AB4E is loaded as-is). Alignment checking belongs elsewhere.
- Result and PCSrc are ignored except at rising edges. Glitches between edges have no effect.
- PCSrc is a level, not a pulse detector. Holding PCSrc=1 for N edges loads Result on every one of those edges.
- No stall/enable. The PC updates on every edge.

Test Plan:
- Hold Reset=0, PCSrc=0, Result=32'h2914AB4E for 2 edges -> PC=32'h00000000, PC_Plus_4=32'h00000004 (Result ignored during reset).
- Release Reset=1, PCSrc=0 for 10 edges -> PC steps 4,8,...,32'h00000028; PC_Plus_4 is always PC+4.
- PCSrc=1 for exactly one edge with Result=32'h2914AB4E, then PCSrc=0 -> PC=32'h2914AB4E and PC_Plus_4=32'h2914AB52; next edge PC=32'h2914AB52, then 32'h2914AB56.
- Redirect to Result=32'hFFFFFFFC, then sequential -> PC_Plus_4=32'h00000000 while PC=32'hFFFFFFFC; next edge PC=32'h00000000.
- Mid-run Reset=0 together with PCSrc=1, Result=32'h12345678 -> PC=32'h00000000 after the edge (reset wins). Deassert Reset -> counting resumes from 4.
- Toggle Result arbitrarily between edges with PCSrc=0, and pulse Reset low between edges -> PC follows the pure +4 sequence, unaffected.
